// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between instruction fetch and load/store.
// Build option MEM_ARB_RR_EN: round-robin on ties (pointer flop present);
// otherwise fixed priority with LS winning every tie and no pointer state.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_if_vld,
    input  logic   i_ls_vld,
    input  logic   i_accept,
    output logic   o_grant_if,
    output logic   o_grant_ls,
    output owner_e o_owner
);

    logic w_tie_ls;

`ifdef MEM_ARB_RR_EN
    owner_e r_last;

    // Remember who was granted last so a tie goes to the other requester
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= OWN_IF;
        end else if (i_accept) begin
            r_last <= o_owner;
        end
    end

    assign w_tie_ls = (r_last == OWN_IF);
`else
    logic w_unused;
    assign w_unused = ^{i_clk, i_rst_n, i_accept};
    assign w_tie_ls = 1'b1;
`endif

    // Single winner: LS takes it alone or on a tie it is entitled to
    always_comb begin
        o_grant_ls = i_ls_vld && (!i_if_vld || w_tie_ls);
        o_grant_if = i_if_vld && !o_grant_ls;
        o_owner    = o_grant_ls ? OWN_LS : OWN_IF;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the LSU.
// One transaction at a time: IDLE -> ISSUE -> (WAIT) -> IDLE, with a
// response timeout and a sticky spurious-response flag.
// Build option MEM_ARB_RR_EN selects round-robin tie breaking.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                if_req_vld,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_req_rdy,
    output logic                if_rsp_vld,
    output logic [DATA_W-1:0]   if_rsp_data,
    output logic                if_rsp_err,
    input  logic                ls_req_vld,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic                ls_wren,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_bmask,
    output logic                ls_req_rdy,
    output logic                ls_rsp_vld,
    output logic [DATA_W-1:0]   ls_rsp_data,
    output logic                ls_rsp_err,
    output logic                mem_req_vld,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wren,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_bmask,
    input  logic                mem_req_rdy,
    input  logic                mem_rsp_vld,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    output logic                busy,
    output logic                spur_rsp
);

    localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT_CYC - 1);

    state_e                r_state;
    owner_e                r_owner;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_wren;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_bmask;
    logic [15:0]           r_cnt;
    logic                  r_if_rsp_vld, r_if_rsp_err;
    logic                  r_ls_rsp_vld, r_ls_rsp_err;
    logic [DATA_W-1:0]     r_if_rsp_data, r_ls_rsp_data;
    logic                  r_spur;

    logic                  w_idle, w_accept;
    logic                  w_grant_if, w_grant_ls;
    owner_e                w_owner;
    logic                  w_done, w_done_err;
    logic [DATA_W-1:0]     w_done_data;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle && (if_req_vld || ls_req_vld);

    mem_arb_grant u_grant (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_if_vld   (if_req_vld),
        .i_ls_vld   (ls_req_vld),
        .i_accept   (w_accept),
        .o_grant_if (w_grant_if),
        .o_grant_ls (w_grant_ls),
        .o_owner    (w_owner)
    );

    assign if_req_rdy  = w_idle && w_grant_if;
    assign ls_req_rdy  = w_idle && w_grant_ls;
    assign mem_req_vld = (r_state == ISSUE);
    assign mem_addr    = r_addr;
    assign mem_wren    = r_wren;
    assign mem_wdata   = r_wdata;
    assign mem_bmask   = r_bmask;
    assign busy        = !w_idle;
    assign spur_rsp    = r_spur;
    assign if_rsp_vld  = r_if_rsp_vld;
    assign if_rsp_data = r_if_rsp_data;
    assign if_rsp_err  = r_if_rsp_err;
    assign ls_rsp_vld  = r_ls_rsp_vld;
    assign ls_rsp_data = r_ls_rsp_data;
    assign ls_rsp_err  = r_ls_rsp_err;

    // Detect transaction completion: store handshake, read data, or timeout
    always_comb begin
        w_done      = 1'b0;
        w_done_err  = 1'b0;
        w_done_data = '0;
        case (r_state)
            ISSUE: begin
                if (mem_req_rdy && r_wren) w_done = 1'b1;
            end
            WAIT: begin
                if (mem_rsp_vld) begin
                    w_done      = 1'b1;
                    w_done_data = mem_rsp_data;
                end else if (r_cnt == LP_TMO_LAST) begin
                    w_done     = 1'b1;
                    w_done_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Transaction FSM: capture on accept, hold mem_* through ISSUE, count in WAIT
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_owner <= OWN_IF;
            r_addr  <= '0;
            r_wren  <= 1'b0;
            r_wdata <= '0;
            r_bmask <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_owner;
                        r_state <= ISSUE;
                        if (w_owner == OWN_LS) begin
                            r_addr  <= ls_addr;
                            r_wren  <= ls_wren;
                            r_wdata <= ls_wdata;
                            r_bmask <= ls_bmask;
                        end else begin
                            r_addr  <= if_addr;
                            r_wren  <= 1'b0;
                            r_wdata <= '0;
                            r_bmask <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_req_rdy) begin
                        if (r_wren) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (w_done) r_state <= IDLE;
                    else        r_cnt   <= r_cnt + 16'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Registered response pulse to the owner; data/err hold between pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_if_rsp_vld  <= 1'b0;
            r_if_rsp_err  <= 1'b0;
            r_if_rsp_data <= '0;
            r_ls_rsp_vld  <= 1'b0;
            r_ls_rsp_err  <= 1'b0;
            r_ls_rsp_data <= '0;
        end else begin
            r_if_rsp_vld <= 1'b0;
            r_ls_rsp_vld <= 1'b0;
            if (w_done) begin
                if (r_owner == OWN_LS) begin
                    r_ls_rsp_vld  <= 1'b1;
                    r_ls_rsp_err  <= w_done_err;
                    r_ls_rsp_data <= w_done_data;
                end else begin
                    r_if_rsp_vld  <= 1'b1;
                    r_if_rsp_err  <= w_done_err;
                    r_if_rsp_data <= w_done_data;
                end
            end
        end
    end

    // Sticky flag for memory responses arriving when none is expected
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_spur <= 1'b0;
        end else if (mem_rsp_vld && (r_state != WAIT)) begin
            r_spur <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single transactions plus
// hand-written sequences for stalls, ties, timeout, reset and back-to-back.
module tb_mem_port_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        if_req_vld;
    logic [31:0] if_addr;
    logic        if_req_rdy, if_rsp_vld, if_rsp_err;
    logic [31:0] if_rsp_data;
    logic        ls_req_vld, ls_wren;
    logic [31:0] ls_addr, ls_wdata;
    logic [3:0]  ls_bmask;
    logic        ls_req_rdy, ls_rsp_vld, ls_rsp_err;
    logic [31:0] ls_rsp_data;
    logic        mem_req_vld, mem_wren;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_bmask;
    logic        mem_req_rdy, mem_rsp_vld;
    logic [31:0] mem_rsp_data;
    logic        busy, spur_rsp;

    int n_chk = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .if_req_vld(if_req_vld), .if_addr(if_addr), .if_req_rdy(if_req_rdy),
        .if_rsp_vld(if_rsp_vld), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .ls_req_vld(ls_req_vld), .ls_addr(ls_addr), .ls_wren(ls_wren),
        .ls_wdata(ls_wdata), .ls_bmask(ls_bmask), .ls_req_rdy(ls_req_rdy),
        .ls_rsp_vld(ls_rsp_vld), .ls_rsp_data(ls_rsp_data), .ls_rsp_err(ls_rsp_err),
        .mem_req_vld(mem_req_vld), .mem_addr(mem_addr), .mem_wren(mem_wren),
        .mem_wdata(mem_wdata), .mem_bmask(mem_bmask), .mem_req_rdy(mem_req_rdy),
        .mem_rsp_vld(mem_rsp_vld), .mem_rsp_data(mem_rsp_data),
        .busy(busy), .spur_rsp(spur_rsp)
    );

    typedef struct {
        logic        is_ls;
        logic        wren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
        logic [31:0] rdata;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        #2;
        i_rst_n = 1'b1;
        tick();
    endtask

    // One complete transaction, memory ready at once, read data one cycle after issue
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        if_req_vld = !v.is_ls;
        if_addr    = v.addr;
        ls_req_vld = v.is_ls;
        ls_addr    = v.addr;
        ls_wren    = v.wren;
        ls_wdata   = v.wdata;
        ls_bmask   = v.bmask;
        #1;
        chk({tag, "_rdy"}, v.is_ls ? ls_req_rdy : if_req_rdy, 32'd1);
        chk({tag, "_other_rdy"}, v.is_ls ? if_req_rdy : ls_req_rdy, 32'd0);
        tick();
        if_req_vld  = 1'b0;
        ls_req_vld  = 1'b0;
        mem_req_rdy = 1'b1;
        chk({tag, "_mem_vld"}, mem_req_vld, 32'd1);
        chk({tag, "_mem_addr"}, mem_addr, v.addr);
        chk({tag, "_mem_wren"}, mem_wren, v.wren);
        if (v.wren) begin
            chk({tag, "_mem_wdata"}, mem_wdata, v.wdata);
            chk({tag, "_mem_bmask"}, mem_bmask, v.bmask);
        end
        tick();
        mem_req_rdy = 1'b0;
        if (!v.wren) begin
            chk({tag, "_wait_busy"}, busy, 32'd1);
            chk({tag, "_wait_mem_vld"}, mem_req_vld, 32'd0);
            mem_rsp_vld  = 1'b1;
            mem_rsp_data = v.rdata;
            tick();
            mem_rsp_vld  = 1'b0;
        end
        chk({tag, "_rsp_vld"}, v.is_ls ? ls_rsp_vld : if_rsp_vld, 32'd1);
        chk({tag, "_other_rsp_vld"}, v.is_ls ? if_rsp_vld : ls_rsp_vld, 32'd0);
        chk({tag, "_rsp_data"}, v.is_ls ? ls_rsp_data : if_rsp_data, v.exp_data);
        chk({tag, "_rsp_err"}, v.is_ls ? ls_rsp_err : if_rsp_err, 32'd0);
        chk({tag, "_busy_done"}, busy, 32'd0);
        tick();
        chk({tag, "_rsp_pulse_end"}, v.is_ls ? ls_rsp_vld : if_rsp_vld, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_ls;
        vec_t v;

        tbl[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'h0,    32'h0051_3093, 32'h0051_3093};
        tbl[1] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         4'hF,    32'hCAFE_F00D, 32'hCAFE_F00D};
        tbl[2] = '{1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0011, 32'h0,         32'h0};
        tbl[3] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0,         4'h0,    32'h1234_5678, 32'h1234_5678};
        tbl[4] = '{1'b1, 1'b1, 32'h0000_3004, 32'hA5A5_5A5A, 4'b1111, 32'h0,         32'h0};

        i_rst_n = 1'b0;
        if_req_vld = 0; if_addr = 0;
        ls_req_vld = 0; ls_addr = 0; ls_wren = 0; ls_wdata = 0; ls_bmask = 0;
        mem_req_rdy = 0; mem_rsp_vld = 0; mem_rsp_data = 0;
        #1;
        chk("rst_busy", busy, 32'd0);
        chk("rst_spur", spur_rsp, 32'd0);
        chk("rst_mem_vld", mem_req_vld, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_rsp_vld", if_rsp_vld, 32'd0);
        chk("rst_ls_rsp_vld", ls_rsp_vld, 32'd0);
        chk("rst_if_rsp_data", if_rsp_data, 32'd0);
        chk("rst_ls_rsp_data", ls_rsp_data, 32'd0);
        #6;
        i_rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_vec(tbl[i], i);

        // Store stalled by memory for three cycles
        ls_req_vld = 1; ls_wren = 1; ls_addr = 32'h2000; ls_wdata = 32'hDEAD_BEEF; ls_bmask = 4'b0011;
        #1;
        chk("st_rdy", ls_req_rdy, 32'd1);
        tick();
        ls_req_vld = 0; ls_wren = 0; ls_wdata = 0; ls_addr = 0; ls_bmask = 0;
        for (int i = 0; i < 3; i++) begin
            chk("st_hold_vld", mem_req_vld, 32'd1);
            chk("st_hold_addr", mem_addr, 32'h2000);
            chk("st_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("st_hold_bmask", mem_bmask, 32'h3);
            chk("st_hold_wren", mem_wren, 32'd1);
            chk("st_hold_no_rsp", ls_rsp_vld, 32'd0);
            tick();
        end
        mem_req_rdy = 1;
        chk("st_issue_vld", mem_req_vld, 32'd1);
        tick();
        mem_req_rdy = 0;
        chk("st_rsp_vld", ls_rsp_vld, 32'd1);
        chk("st_rsp_data", ls_rsp_data, 32'd0);
        chk("st_if_rsp_vld", if_rsp_vld, 32'd0);

        // Four back-to-back ties from reset
        apply_reset();
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_ls = (k % 2 == 0);
`else
            exp_ls = 1'b1;
`endif
            if_req_vld = 1; if_addr = 32'h100 + 32'(k * 4);
            ls_req_vld = 1; ls_addr = 32'h200 + 32'(k * 4); ls_wren = 0;
            #1;
            chk($sformatf("tie%0d_ls_rdy", k), ls_req_rdy, 32'(exp_ls));
            chk($sformatf("tie%0d_if_rdy", k), if_req_rdy, 32'(!exp_ls));
            tick();
            if_req_vld = 0; ls_req_vld = 0; mem_req_rdy = 1;
            chk($sformatf("tie%0d_addr", k), mem_addr,
                exp_ls ? 32'h200 + 32'(k * 4) : 32'h100 + 32'(k * 4));
            tick();
            mem_req_rdy = 0; mem_rsp_vld = 1; mem_rsp_data = 32'h1000 + 32'(k);
            tick();
            mem_rsp_vld = 0;
            chk($sformatf("tie%0d_ls_rsp", k), ls_rsp_vld, 32'(exp_ls));
            chk($sformatf("tie%0d_if_rsp", k), if_rsp_vld, 32'(!exp_ls));
        end
        tick();

        // Read timeout then a spurious response in IDLE
        ls_req_vld = 1; ls_addr = 32'h500; ls_wren = 0;
        #1;
        chk("to_rdy", ls_req_rdy, 32'd1);
        tick();
        ls_req_vld = 0; mem_req_rdy = 1;
        tick();
        mem_req_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_busy", busy, 32'd1);
            chk("to_wait_no_rsp", ls_rsp_vld, 32'd0);
            tick();
        end
        chk("to_rsp_vld", ls_rsp_vld, 32'd1);
        chk("to_rsp_err", ls_rsp_err, 32'd1);
        chk("to_rsp_data", ls_rsp_data, 32'd0);
        chk("to_busy", busy, 32'd0);
        chk("to_spur_clear", spur_rsp, 32'd0);
        mem_rsp_vld = 1; mem_rsp_data = 32'h7777_7777;
        tick();
        mem_rsp_vld = 0;
        chk("spur_set", spur_rsp, 32'd1);
        chk("spur_no_rsp", ls_rsp_vld, 32'd0);
        tick();
        chk("spur_sticky", spur_rsp, 32'd1);

        // Asynchronous reset during WAIT
        if_req_vld = 1; if_addr = 32'h40;
        tick();
        if_req_vld = 0; mem_req_rdy = 1;
        tick();
        mem_req_rdy = 0;
        chk("rw_busy_wait", busy, 32'd1);
        i_rst_n = 0;
        #1;
        chk("rw_busy_async", busy, 32'd0);
        chk("rw_spur_cleared", spur_rsp, 32'd0);
        #2;
        i_rst_n = 1;
        tick();
        chk("rw_no_if_rsp", if_rsp_vld, 32'd0);
        chk("rw_no_ls_rsp", ls_rsp_vld, 32'd0);
        v = tbl[0];
        run_vec(v, 9);

        // New fetch accepted during the response pulse cycle
        if_req_vld = 1; if_addr = 32'h80;
        tick();
        if_req_vld = 0; mem_req_rdy = 1;
        tick();
        mem_req_rdy = 0; mem_rsp_vld = 1; mem_rsp_data = 32'hAAAA_0001;
        tick();
        mem_rsp_vld = 0;
        if_req_vld = 1; if_addr = 32'h84;
        #1;
        chk("b2b_rsp_vld", if_rsp_vld, 32'd1);
        chk("b2b_rsp_data", if_rsp_data, 32'hAAAA_0001);
        chk("b2b_rdy", if_req_rdy, 32'd1);
        tick();
        if_req_vld = 0; mem_req_rdy = 1;
        chk("b2b_addr2", mem_addr, 32'h84);
        chk("b2b_rsp_end", if_rsp_vld, 32'd0);
        tick();
        mem_req_rdy = 0; mem_rsp_vld = 1; mem_rsp_data = 32'hBBBB_0002;
        tick();
        mem_rsp_vld = 0;
        chk("b2b_rsp2_vld", if_rsp_vld, 32'd1);
        chk("b2b_rsp2_data", if_rsp_data, 32'hBBBB_0002);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory between two requesters: instruction fetch (IF) and the load/store unit (LS).
- Sits between the fetch/LSU logic and the memory macro, and supports a multi-cycle or stalled-core variant of the datapath.
- Accepts at most one transaction at a time, sequences it through issue and response, and returns the result to the owner.
- Includes a response timeout and spurious-response detection.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- TIMEOUT_CYC, 255, maximum cycles spent in WAIT before forced error completion; range 1..65535.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- if_req_vld  in  1  fetch read request.
- if_addr  in  ADDR_W  fetch address.
- if_req_rdy  out  1  fetch request accepted.
- if_rsp_vld  out  1  fetch response pulse.
- if_rsp_data  out  DATA_W  fetch read data.
- if_rsp_err  out  1  fetch response error (timeout).
- ls_req_vld  in  1  LSU request.
- ls_addr  in  ADDR_W  LSU address.
- ls_wren  in  1  1 = store, 0 = load.
- ls_wdata  in  DATA_W  store data.
- ls_bmask  in  DATA_W/8  store byte enables.
- ls_req_rdy  out  1  LSU request accepted.
- ls_rsp_vld  out  1  LSU response pulse.
- ls_rsp_data  out  DATA_W  load data (0 for stores).
- ls_rsp_err  out  1  LSU response error (timeout).
- mem_req_vld  out  1  request to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wren  out  1  memory write.
- mem_wdata  out  DATA_W  memory write data.
- mem_bmask  out  DATA_W/8  memory byte enables.
- mem_req_rdy  in  1  memory accepts request.
- mem_rsp_vld  in  1  memory read data valid.
- mem_rsp_data  in  DATA_W  memory read data.
- busy  out  1  state != IDLE.
- spur_rsp  out  1  sticky flag: mem_rsp_vld seen outside WAIT.

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: all outputs 0, state = IDLE, RR pointer = IF, timeout counter = 0. A reset mid-transaction abandons it; no response pulse is produced for it.
- Requester handshake: a request is accepted on the cycle where x_req_vld && x_req_rdy. Requesters hold vld, addr and data stable until accepted. x_req_rdy is combinational and is 1 only in IDLE, for the granted requester only.
- Arbitration: in IDLE, if one requester is valid it is granted. If both are valid, the grant follows the compiled policy (see Optional Feature).
- On acceptance, the request is captured into internal registers and an owner bit is set; next state is ISSUE.
- ISSUE: mem_req_vld = 1 and mem_* are driven from the registers.
  - If mem_req_rdy and the request is a store: go to IDLE; the owner's rsp_vld pulses the next cycle with rsp_data = 0.
  - If mem_req_rdy and the request is a read: go to WAIT and clear the timeout counter.
  - Otherwise stay in ISSUE with mem_* held unchanged.
- WAIT: mem_req_vld = 0.
  - If mem_rsp_vld: register mem_rsp_data to the owner and go to IDLE; the owner's rsp_vld pulses for 1 cycle the next cycle, with err = 0.
  - Else, if the counter equals TIMEOUT_CYC - 1: go to IDLE; the owner's rsp_vld pulses with err = 1 and data = 0.
  - Else increment the counter.
- Response outputs: registered, 1-cycle pulses. A new request may be accepted in the same cycle a response pulse is presented, because state is already IDLE. rsp_data and rsp_err hold their last value between pulses.
- mem_rsp_vld in IDLE or ISSUE sets spur_rsp, which is cleared only by reset; the data is discarded.
- Read latency: accept at cycle N, issue at N+1. With mem_rsp_vld at N+2, rsp_vld is at N+3. Minimum store turnaround: accept N, issue N+1, rsp_vld N+2.
- Non-owner rsp_vld is always 0.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin. On a simultaneous request, grant the requester not granted last. The pointer updates on every acceptance; after reset, LS wins the first tie.
- Undefined: fixed priority, LS always wins ties; the RR pointer register is not instantiated.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT};
  - owner enum {OWN_IF = 1'b0, OWN_LS = 1'b1};
  - localparam DEF_TIMEOUT = 255.
- One sub-module, mem_arb_grant: combinational grant logic plus the RR pointer flop (clocked only under MEM_ARB_RR_EN). Its outputs are grant_if, grant_ls and the owner.

Test Plan:
- Single fetch: if_req_vld, if_addr = 0x0000_0010, mem ready immediately, mem_rsp_vld one cycle after issue with data 0x0051_3093 -> if_rsp_vld at accept+3, if_rsp_data = 0x0051_3093, err = 0, ls_rsp_vld stays 0.
- Store: ls_wren = 1, addr 0x2000, wdata 0xDEAD_BEEF, bmask 4'b0011, mem_req_rdy held low 3 cycles -> mem_* stable throughout ISSUE; ls_rsp_vld pulses the cycle after mem_req_rdy, with data 0.
- Simultaneous requests, 4 back-to-back pairs -> fixed priority: LS granted every tie; with MEM_ARB_RR_EN: grant order LS, IF, LS, IF.
- Timeout: TIMEOUT_CYC = 4, read issued, mem_rsp_vld never asserted -> ls_rsp_err = 1 and ls_rsp_vld pulse 4 cycles after entering WAIT; a later mem_rsp_vld in IDLE sets spur_rsp = 1.
- Reset mid-WAIT: i_rst_n low asynchronously -> busy = 0 immediately, no rsp pulse; the next fetch completes normally.
- Back-to-back: a new if_req_vld present during the response-pulse cycle -> accepted in that same cycle (if_req_rdy = 1).
